demux18_frame: RTL

//   Registered 1:8 demultiplexer/frame assembler, the receive-side counterpart of the team's 8:1 bit mux.

---
 rtl/demux18_frame.sv | 114 +++++++++++
 1 files changed

// File: rtl/demux18_frame.sv
// Registered 1:8 demultiplexer / frame assembler: serial bits land in lane registers
// and a completed byte is published with a one-cycle valid pulse. Option macro: DEMUX_PARITY_EN.
module demux18_frame (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d,
    input  logic       d_valid,
    input  logic [2:0] s,
    input  logic       auto,
    input  logic       clr,
    output logic [7:0] lanes,
    output logic [7:0] frame,
    output logic       frame_valid,
    output logic [2:0] ptr,
    output logic       busy
`ifdef DEMUX_PARITY_EN
    ,
    output logic       frame_par
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] mask;
    logic [7:0] onehot;
    logic [7:0] mask_upd;
    logic [7:0] lanes_upd;
    logic [2:0] idx;
    logic       wr;
    logic       complete;

`ifdef DEMUX_PARITY_EN
    function automatic logic frame_parity(input logic [7:0] v);
        return ^v;
    endfunction
`endif

    // External select arrives bit-reversed from the upstream mux chain.
    always_comb begin
        idx       = auto ? ptr : {s[0], s[1], s[2]};
        wr        = d_valid && !clr;
        onehot    = 8'b1 << idx;
        mask_upd  = mask | onehot;
        lanes_upd = lanes;
        lanes_upd[idx] = d;
        complete  = wr && (mask_upd == 8'hFF);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (wr)
                    state_nx = complete ? DONE : FILL;
            end
            FILL: begin
                if (clr)
                    state_nx = IDLE;
                else if (complete)
                    state_nx = DONE;
            end
            DONE: begin
                // A write in the pulse cycle starts the next frame without a bubble.
                state_nx = wr ? FILL : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes <= 8'h00;
            frame <= 8'h00;
            mask  <= 8'h00;
            ptr   <= 3'd0;
        end else if (clr) begin
            lanes <= 8'h00;
            mask  <= 8'h00;
            ptr   <= 3'd0;
        end else if (wr) begin
            lanes <= lanes_upd;
            if (complete) begin
                frame <= lanes_upd;
                mask  <= 8'h00;
                ptr   <= 3'd0;
            end else begin
                mask <= mask_upd;
                if (auto)
                    ptr <= ptr + 3'd1;
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_par <= 1'b0;
        else if (complete)
            frame_par <= frame_parity(lanes_upd);
    end
`endif

    assign frame_valid = (state == DONE);
    assign busy        = (state == FILL);

endmodule
